// File: rtl/vid_pkg.sv
// Shared video-path definitions: packer state encoding, start-code prefix and
// the legal output word widths.
package vid_pkg;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } pack_state_e;

   localparam logic [23:0] START_CODE_PREFIX = 24'h000001;

   localparam int unsigned WORD_BYTES_4 = 4;
   localparam int unsigned WORD_BYTES_8 = 8;

   function automatic bit word_bytes_legal(int unsigned wb);
      return (wb == WORD_BYTES_4) || (wb == WORD_BYTES_8);
   endfunction

endpackage

// File: rtl/vid_startcode_detect.sv
// Tracks the last three bytes of a byte stream and flags the byte that
// follows an MPEG 00 00 01 start-code prefix.
module vid_startcode_detect
   import vid_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_en,
   input  logic       byte_valid,
   input  logic [7:0] byte_in,
   output logic       sc_valid,
   output logic [7:0] sc_code
);

   logic [23:0] hist_q, hist_d;
   logic        flag_q, flag_d;
   logic [7:0]  code_q, code_d;

   always_comb begin
      hist_d = hist_q;
      code_d = code_q;
      flag_d = 1'b0;
      if (byte_valid) begin
         hist_d = {hist_q[15:0], byte_in};
         if (hist_q == START_CODE_PREFIX) begin
            flag_d = 1'b1;
            code_d = byte_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hist_q <= 24'hFFFFFF;
         flag_q <= 1'b0;
         code_q <= 8'h00;
      end else if (clk_en) begin
         hist_q <= hist_d;
         flag_q <= flag_d;
         code_q <= code_d;
      end
   end

   assign sc_valid = flag_q && clk_en;
   assign sc_code  = code_q;

endmodule

// File: rtl/vid_word_packer.sv
// Drains the video byte FIFO into big-endian vbuf words, pads and flushes the
// tail at end of stream. Start-code flagging under VID_WORD_PACKER_STARTCODE_EN.
module vid_word_packer
   import vid_pkg::*;
#(
   parameter int unsigned WORD_BYTES = 8,
   parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clk_en,
   input  logic [7:0]              vid_in,
   input  logic                    vid_empty,
   output logic                    vid_rd,
   input  logic                    stream_end_in,
   input  logic                    vbuf_afull,
   output logic [8*WORD_BYTES-1:0] vbuf_out,
   output logic                    vbuf_wr,
   output logic                    stream_end_out,
   output logic                    sc_valid,
   output logic [7:0]              sc_code
);

   localparam int unsigned W  = 8 * WORD_BYTES;
   localparam int unsigned CW = $clog2(WORD_BYTES);
   localparam logic [CW-1:0] LAST_LANE = CW'(WORD_BYTES - 1);

   if (!word_bytes_legal(WORD_BYTES)) begin : g_bad_word_bytes
      $error("vid_word_packer: WORD_BYTES must be 4 or 8");
   end

   pack_state_e   state_q, state_d;
   logic [CW-1:0] byte_cnt_q, byte_cnt_d;
   logic [W-1:0]  word_q, word_d;
   logic [W-1:0]  vbuf_out_q, vbuf_out_d;
   logic          byte_ready_q, end_seen_q, end_seen_d;
   logic          wr_flag_q, wr_flag_d;
   logic          stream_end_q, stream_end_d;
   logic          rd_accepted, end_set, flush_go;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= FILL;
      end else if (clk_en) begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL: begin
            if (end_seen_q) state_d = (byte_cnt_q == '0) ? DONE : FLUSH;
         end
         FLUSH: begin
            if (!vbuf_afull) state_d = DONE;
         end
         DONE:    state_d = DONE;
         default: state_d = FILL;
      endcase
   end

   // FSM: outputs
   always_comb begin
      vid_rd       = rst && clk_en && !vbuf_afull && (state_q == FILL) && !end_seen_q;
      flush_go     = (state_q == FLUSH) && !vbuf_afull;
      // Stream end is reported one cycle after the last word leaves.
      stream_end_d = stream_end_q || (state_q == DONE)
                     || ((state_q == FILL) && (state_d == DONE));
   end

   assign rd_accepted = vid_rd && !vid_empty;
   assign end_set     = stream_end_in && vid_empty && !byte_ready_q && !rd_accepted;
   assign end_seen_d  = end_seen_q || end_set;

   // Lane insertion, word completion and tail padding
   always_comb begin
      word_d     = word_q;
      byte_cnt_d = byte_cnt_q;
      vbuf_out_d = vbuf_out_q;
      wr_flag_d  = 1'b0;
      if (byte_ready_q) begin
         word_d[(int'(WORD_BYTES) - 1 - int'(byte_cnt_q)) * 8 +: 8] = vid_in;
         if (byte_cnt_q == LAST_LANE) begin
            vbuf_out_d = word_d;
            wr_flag_d  = 1'b1;
            byte_cnt_d = '0;
         end else begin
            byte_cnt_d = byte_cnt_q + CW'(1);
         end
      end else if (flush_go) begin
         for (int i = 0; i < int'(WORD_BYTES); i++) begin
            if (i >= int'(byte_cnt_q)) begin
               word_d[(int'(WORD_BYTES) - 1 - i) * 8 +: 8] = PAD_BYTE;
            end
         end
         vbuf_out_d = word_d;
         wr_flag_d  = 1'b1;
         byte_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         byte_cnt_q   <= '0;
         word_q       <= '0;
         vbuf_out_q   <= '0;
         byte_ready_q <= 1'b0;
         end_seen_q   <= 1'b0;
         wr_flag_q    <= 1'b0;
         stream_end_q <= 1'b0;
      end else if (clk_en) begin
         byte_cnt_q   <= byte_cnt_d;
         word_q       <= word_d;
         vbuf_out_q   <= vbuf_out_d;
         byte_ready_q <= rd_accepted;
         end_seen_q   <= end_seen_d;
         wr_flag_q    <= wr_flag_d;
         stream_end_q <= stream_end_d;
      end
   end

   assign vbuf_out       = vbuf_out_q;
   assign vbuf_wr        = wr_flag_q && clk_en;
   assign stream_end_out = stream_end_q;

`ifdef VID_WORD_PACKER_STARTCODE_EN
   vid_startcode_detect u_sc_detect (
      .clk        (clk),
      .rst        (rst),
      .clk_en     (clk_en),
      .byte_valid (byte_ready_q),
      .byte_in    (vid_in),
      .sc_valid   (sc_valid),
      .sc_code    (sc_code)
   );
`else
   assign sc_valid = 1'b0;
   assign sc_code  = 8'h00;
`endif

endmodule

// File: tb/tb_vid_word_packer.sv
// Directed bench for vid_word_packer (WORD_BYTES=8) with a small byte-FIFO model.
module tb_vid_word_packer;

   logic        clk = 1'b0;
   logic        rst, clk_en, vid_empty, vid_rd, stream_end_in, vbuf_afull;
   logic [7:0]  vid_in = 8'h00;
   logic [63:0] vbuf_out;
   logic        vbuf_wr, stream_end_out, sc_valid;
   logic [7:0]  sc_code;

   int n_checks = 0;
   int n_fail   = 0;

   int          cyc = 0;
   logic [7:0]  mem [0:255];
   int          rd_ptr = 0;
   int          wr_ptr = 0;
   int          last_rd_cyc = 0;
   logic [63:0] wr_word [0:15];
   int          wr_count = 0;
   int          last_wr_cyc = 0;
   int          sc_pulses = 0;
   int          seo_rise = 0;
   logic        seo_prev = 1'b0;
   int          base;

   vid_word_packer u_dut (
      .clk            (clk),
      .rst            (rst),
      .clk_en         (clk_en),
      .vid_in         (vid_in),
      .vid_empty      (vid_empty),
      .vid_rd         (vid_rd),
      .stream_end_in  (stream_end_in),
      .vbuf_afull     (vbuf_afull),
      .vbuf_out       (vbuf_out),
      .vbuf_wr        (vbuf_wr),
      .stream_end_out (stream_end_out),
      .sc_valid       (sc_valid),
      .sc_code        (sc_code)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Show-ahead-free FIFO model: data appears after the read edge
   assign vid_empty = (rd_ptr == wr_ptr);
   always @(posedge clk) begin
      if (vid_rd && !vid_empty) begin
         vid_in      <= mem[rd_ptr[7:0]];
         rd_ptr      <= rd_ptr + 1;
         last_rd_cyc <= cyc;
      end
   end

   always @(negedge clk) begin
      if (vbuf_wr) begin
         if (wr_count < 16) wr_word[wr_count[3:0]] <= vbuf_out;
         wr_count    <= wr_count + 1;
         last_wr_cyc <= cyc;
      end
      if (sc_valid) sc_pulses <= sc_pulses + 1;
      if (stream_end_out && !seo_prev) seo_rise <= cyc;
      seo_prev <= stream_end_out;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr[7:0]] = b;
      wr_ptr++;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      stream_end_in = 1'b0;
      vbuf_afull    = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; clk_en = 1'b1; stream_end_in = 1'b0; vbuf_afull = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("reset_vid_rd", 64'(vid_rd), 64'd0);
      check_eq("reset_vbuf_out", vbuf_out, 64'd0);
      check_eq("reset_vbuf_wr", 64'(vbuf_wr), 64'd0);
      check_eq("reset_stream_end", 64'(stream_end_out), 64'd0);
      check_eq("reset_sc_valid", 64'(sc_valid), 64'd0);
      check_eq("reset_sc_code", 64'(sc_code), 64'd0);
      @(posedge clk);
      #1 rst = 1'b1;

      // Full word 01..08 and read-to-write latency
      base = wr_count;
      for (int i = 1; i <= 8; i++) push(8'(i));
      settle(15);
      check_eq("word1_count", 64'(wr_count - base), 64'd1);
      check_eq("word1_data", wr_word[base[3:0]], 64'h0102030405060708);
      check_eq("word1_latency", 64'(last_wr_cyc - last_rd_cyc), 64'd2);

      // clk_en dropped mid-word: everything holds
      base = wr_count;
      for (int i = 0; i < 8; i++) push(8'h31 + 8'(i));
      settle(3);
      clk_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("clken_vid_rd", 64'(vid_rd), 64'd0);
      end
      check_eq("clken_vbuf_wr", 64'(vbuf_wr), 64'd0);
      @(posedge clk);
      #1 clk_en = 1'b1;
      settle(15);
      check_eq("clken_count", 64'(wr_count - base), 64'd1);
      check_eq("clken_data", wr_word[base[3:0]], 64'h3132333435363738);

      // vbuf_afull held 10 cycles mid-word
      base = wr_count;
      for (int i = 0; i < 4; i++) push(8'h21 + 8'(i));
      settle(2);
      vbuf_afull = 1'b1;
      for (int i = 0; i < 4; i++) push(8'h25 + 8'(i));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq("afull_vid_rd", 64'(vid_rd), 64'd0);
      end
      check_eq("afull_no_write", 64'(wr_count - base), 64'd0);
      @(posedge clk);
      #1 vbuf_afull = 1'b0;
      settle(15);
      check_eq("afull_count", 64'(wr_count - base), 64'd1);
      check_eq("afull_data", wr_word[base[3:0]], 64'h2122232425262728);

      // Reset mid-word discards the partial word
      base = wr_count;
      for (int i = 0; i < 5; i++) push(8'h51 + 8'(i));
      settle(10);
      do_reset();
      settle(3);
      check_eq("rstmid_no_write", 64'(wr_count - base), 64'd0);
      for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
      settle(15);
      check_eq("rstmid_count", 64'(wr_count - base), 64'd1);
      check_eq("rstmid_data", wr_word[base[3:0]], 64'h1112131415161718);

      // Partial word AA BB CC then end of stream
      base = wr_count;
      push(8'hAA); push(8'hBB); push(8'hCC);
      settle(8);
      stream_end_in = 1'b1;
      settle(15);
      check_eq("pad_count", 64'(wr_count - base), 64'd1);
      check_eq("pad_data", wr_word[base[3:0]], 64'hAABBCC0000000000);
      check_eq("pad_stream_end", 64'(stream_end_out), 64'd1);
      check_eq("pad_end_delay", 64'(seo_rise - last_wr_cyc), 64'd1);
      @(negedge clk);
      check_eq("done_vid_rd", 64'(vid_rd), 64'd0);
      settle(5);
      check_eq("done_no_write", 64'(wr_count - base), 64'd1);

      // Exactly 16 bytes then end: two words, no pad word
      do_reset();
      @(negedge clk);
      check_eq("rst_clears_end", 64'(stream_end_out), 64'd0);
      @(posedge clk);
      #1;
      base = wr_count;
      for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
      stream_end_in = 1'b1;
      settle(30);
      check_eq("x16_count", 64'(wr_count - base), 64'd2);
      check_eq("x16_word0", wr_word[base[3:0]], 64'h8081828384858687);
      check_eq("x16_word1", wr_word[4'(base + 1)], 64'h88898A8B8C8D8E8F);
      check_eq("x16_stream_end", 64'(stream_end_out), 64'd1);

      // Start code 00 00 01 B3
      do_reset();
      base = sc_pulses;
      begin
         int wb;
         wb = wr_count;
         push(8'h00); push(8'h00); push(8'h01); push(8'hB3);
         push(8'h00); push(8'h00); push(8'h00); push(8'h00);
         settle(15);
         check_eq("sc_word", wr_word[wb[3:0]], 64'h000001B300000000);
      end
`ifdef VID_WORD_PACKER_STARTCODE_EN
      check_eq("sc_pulses", 64'(sc_pulses - base), 64'd1);
      check_eq("sc_code", 64'(sc_code), 64'hB3);
`else
      check_eq("sc_pulses_off", 64'(sc_pulses), 64'd0);
      check_eq("sc_code_off", 64'(sc_code), 64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vid_word_packer.md
# vid_word_packer

Downstream stage of the program-stream splitter. Drains the video elementary-stream byte FIFO (written by the splitter's `vid_wr`) and packs bytes into big-endian words for the video buffer (vbuf) FIFO. At end of stream it pads and flushes the partial word, then signals completion. Optionally flags MPEG start codes as they pass.

## Interface
- `WORD_BYTES`, default 8: bytes per output word; legal values are 4 or 8.
- `PAD_BYTE`, default 8'h00: fill value used for the unused bytes of the flushed partial word.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `clk_en` in 1: global clock enable. All state advances only when `clk_en` is high.
- `vid_in` in 8: byte from the video FIFO; valid on the enabled cycle after an accepted read.
- `vid_empty` in 1: video FIFO empty.
- `vid_rd` out 1: video FIFO read strobe (combinational).
- `stream_end_in` in 1: upstream stream ended (the splitter's `stream_end_out`).
- `vbuf_afull` in 1: vbuf FIFO almost full (at least 1 free slot guaranteed).
- `vbuf_out` out 8*WORD_BYTES: packed word; byte 0 sits in the MSBs.
- `vbuf_wr` out 1: vbuf write strobe, gated by `clk_en`.
- `stream_end_out` out 1: sticky; the last word has been written.
- `sc_valid` out 1: one-cycle start-code pulse, gated by `clk_en` (macro only).
- `sc_code` out 8: byte following the 00 00 01 prefix (macro only).

## Operation
- Read handshake:
  - `vid_rd = clk_en && ~vbuf_afull && state==FILL && ~end_seen`.
  - A read with `~vid_empty` sets `byte_ready`; `vid_in` is captured on the next enabled cycle.
- Packing:
  - Each captured byte goes to byte lane `byte_cnt` (lane 0 = MSBs), then `byte_cnt` increments.
  - On the byte with `byte_cnt==WORD_BYTES-1`: `vbuf_out` is loaded with the completed word, the write flag is set, and `byte_cnt` wraps to 0.
- End detection: `end_seen` is set when all of these hold on an enabled cycle: `stream_end_in && vid_empty && ~byte_ready && ~vid_rd_accepted`.
- States:
  - FILL: normal packing. Goes to FLUSH when `end_seen && byte_cnt!=0`. Goes to DONE when `end_seen && byte_cnt==0`.
  - FLUSH: waits for `~vbuf_afull`. Then fills lanes `byte_cnt..WORD_BYTES-1` with `PAD_BYTE`, writes the word, and goes to DONE.
  - DONE: sets `stream_end_out`. No further reads or writes. Exit is by reset only.
  - Any illegal encoding goes to FILL.
- `vbuf_wr = wr_flag && clk_en`. `wr_flag` is a register that is high for exactly 1 enabled cycle per word.
- Simultaneous word completion and `end_seen` with `byte_cnt` becoming 0: the full word is written and the state goes directly to DONE; no pad word is produced.
- `vbuf_afull` rising while `byte_ready` is set: the pending byte is still captured. `vbuf_afull` blocks only new reads, and the guaranteed slot absorbs the resulting write.

## Timing
- Reset values: `vid_rd`=0 while `clk_en`=0 or in reset; `vbuf_out`=0; `vbuf_wr`=0; `stream_end_out`=0; `sc_valid`=0; `sc_code`=0. Also `byte_cnt`=0, `byte_ready`=0, state=FILL.
- Latency: a read accepted at cycle n captures at n+1. The word containing that byte as its last byte shows `vbuf_wr` at n+2.
- Throughput: 1 byte per enabled cycle.
- `clk_en` low: all registers hold; `vid_rd`, `vbuf_wr` and `sc_valid` are 0.
- `stream_end_out` rises 1 enabled cycle after the final (possibly padded) write, or 1 cycle after `end_seen` when no partial word exists.
- Reset mid-word: the partial word is discarded; no write occurs.

## Configuration
- `VID_WORD_PACKER_STARTCODE_EN` defined:
  - A 3-byte history of captured bytes (reset 24'hFFFFFF) is tracked.
  - When the history equals 00 00 01 on capture of byte X: `sc_code<=X` and `sc_valid` pulses on the following enabled cycle.
  - Pad bytes are not scanned.
- Macro undefined: `sc_valid` and `sc_code` are tied to 0 and no history registers exist.

## Structure
- Shared package `vid_pkg`:
  - packer state typedef (FILL, FLUSH, DONE);
  - `START_CODE_PREFIX` = 24'h000001;
  - legal `WORD_BYTES` constants.
- Sub-module `vid_startcode_detect`: byte history plus compare, instantiated only under the macro. The same module is reusable by later parser stages.

## Test plan
- Bytes 01..08, `vbuf_afull`=0 → one `vbuf_wr` with `vbuf_out`=64'h0102030405060708, 2 cycles after the read of 08.
- Bytes AA BB CC, then `stream_end_in`=1 with FIFO empty → `vbuf_out`=64'hAABBCC0000000000, then `stream_end_out`=1 on the next enabled cycle.
- Exactly 16 bytes then end → 2 writes, no pad word, `stream_end_out`=1.
- `vbuf_afull` held high for 10 cycles mid-word → `vid_rd`=0 throughout, no byte lost or duplicated, word correct after release.
- With macro: bytes 00 00 01 B3 → `sc_valid` 1-cycle pulse, `sc_code`=8'hB3. Without macro: `sc_valid` stays 0.
- Reset after 5 bytes, then 8 bytes 11..18 → first write is 64'h1112131415161718.
